viterbi_traceback: RTL and testbench
====================================

Name: viterbi_traceback

Overview:
- Frame-based survivor-path traceback stage for the K=7, 64-state hard-decision Viterbi decoder.
- Sits directly downstream of the 64-lane add-compare-select array.
- Each trellis step, it stores the 64-bit decision vector (one select bit per state).
- At frame end it traces back from state 0, which the zero tail guarantees, and streams the decoded data bits out in forward order.

Parameters:
- MAX_LEN, 4096: maximum trellis steps per frame, tail included.
- ADDR_W, 12: address width; must satisfy 2^ADDR_W >= MAX_LEN.
- TAIL, 6: tail steps dropped from the output.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Reset. Asynchronous assert, active low.
- dec_valid  in  1  Decision vector valid.
- dec_vec  in  64  Bit s = ACS decision for next-state s at this step.
- dec_last  in  1  Marks the final step of the frame.
- dec_ready  out  1  Block accepts a decision vector this cycle.
- out_valid  out  1  Decoded bit valid.
- out_bit  out  1  Decoded bit.
- out_last  out  1  Marks the final decoded bit of the frame.
- out_ready  in  1  Downstream accepts the bit.
- busy  out  1  High in TRACE and OUTPUT.
- err_ovf  out  1  Sticky frame-overflow flag.

Behaviour:
- Trellis convention:
  - next = {s[4:0], b}; decoded bit = next[0].
  - Predecessor of s = {dec[s], s[5:1]}.
- Reset: rst_n low asynchronously forces the following. rst_n may drop in any state, including mid-TRACE or mid-OUTPUT; the partial frame is discarded and no out_last is issued.
  - State = WRITE.
  - Step counter = 0.
  - dec_ready = 1.
  - out_valid = 0, out_bit = 0, out_last = 0.
  - busy = 0, err_ovf = 0.
  - Memory contents are don't-care.
- Survivor memory: MAX_LEN x 64, synchronous write, registered read with 1-cycle latency.
- Bit buffer: MAX_LEN x 1.
- WRITE state:
  - dec_ready = 1.
  - Transfer condition: dec_valid & dec_ready. On a transfer, write dec_vec at address = step counter, then increment the counter.
  - On a transfer with dec_last, or on the transfer that writes address MAX_LEN-1, latch L = counter+1 and go to TRACE.
  - Overflow: reaching MAX_LEN without dec_last sets err_ovf. The forced frame is traced normally. Inputs after the forced end are held off by dec_ready = 0; the remainder of the oversize frame is then accepted as a new frame.
  - err_ovf clears on the first transfer of the next frame.
- TRACE state:
  - dec_ready = 0, busy = 1. Start with s = 0, t = L-1.
  - Two cycles per step:
    - Cycle A: issue a read of address t.
    - Cycle B: write bit buffer[t] = s[0]; s <= {rd[s], s[5:1]}; t <= t-1.
  - After step t = 0 completes, go to OUTPUT. Latency is exactly 2L cycles.
  - If L <= TAIL, skip OUTPUT, emit nothing, and return to WRITE.
- OUTPUT state:
  - Streams buffer[0 .. L-TAIL-1] in forward order.
  - Valid/ready handshake: a bit is accepted when out_valid & out_ready.
  - out_valid, out_bit and out_last are registered. They are held stable while out_ready = 0, and out_valid never drops before acceptance.
  - out_last = 1 only with bit index L-TAIL-1.
  - The bit buffer uses a registered read with prefetch, so with out_ready held high the output is one bit per cycle and has no bubbles.
  - After the out_last transfer: out_valid = 0 next cycle, counter = 0, return to WRITE.
- Throughput: no new frame is accepted during TRACE or OUTPUT. dec_valid may be asserted then; it must be held until dec_ready.
- dec_last together with dec_valid = 0 is ignored.

Test Plan:
- All-zero path: 10 steps, dec_vec = 0, dec_last on step 10 -> after 20 TRACE cycles, bits 0,0,0,0 with out_last on the 4th; no bubbles with out_ready = 1.
- Known path: input 1,0,1,1 plus six zero tail bits; dec_vec = 0 except step 7 bit 24 = 1, step 9 bit 32 = 1, step 10 bit 0 = 1 (steps numbered from 1) -> output 1,0,1,1, out_last on the final 1.
- Backpressure: known-path frame with out_ready toggled 1,0,0,1,... -> identical 1,0,1,1 sequence; out_bit and out_valid stable during stalls; dec_ready = 0 until out_last is accepted.
- Short frame: L = 6, all zeros -> no out_valid at all; busy high 12 cycles, then dec_ready = 1.
- Overflow: MAX_LEN+3 zero steps, dec_last on the last -> err_ovf = 1 after step MAX_LEN; MAX_LEN-6 zero bits out; the next 3 steps form a new frame with no output; err_ovf clears on its first transfer.
- Reset mid-operation: assert rst_n low during TRACE, then during OUTPUT -> all outputs 0 immediately; dec_ready = 1 after release; the next known-path frame decodes 1,0,1,1.

Source files
------------

// File: rtl/viterbi_traceback.sv
// Survivor-path traceback for the K=7, 64-state hard-decision Viterbi decoder.
// Stores decision vectors per step, traces back from state 0, streams bits forward.
module viterbi_traceback #(
   parameter int MAX_LEN = 4096,
   parameter int ADDR_W  = 12,
   parameter int TAIL    = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dec_valid,
   input  logic [63:0] dec_vec,
   input  logic        dec_last,
   output logic        dec_ready,
   output logic        out_valid,
   output logic        out_bit,
   output logic        out_last,
   input  logic        out_ready,
   output logic        busy,
   output logic        err_ovf
);

   localparam int LW = ADDR_W + 1;

   typedef enum logic [1:0] {
      WRITE  = 2'd0,
      TRACE  = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [63:0]       smem [MAX_LEN];
   logic              bbuf [MAX_LEN];

   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] t;
   logic [ADDR_W-1:0] ridx;
   logic [ADDR_W-1:0] last_idx;
   logic [LW-1:0]     len;
   logic [LW-1:0]     nout;
   logic [5:0]        s;
   logic              ph;
   logic [63:0]       rd;
   logic              bq;
   logic              pf_v;
   logic              pf_last;
   logic              rd_more;

   logic xfer;
   logic at_end;
   logic frame_end;
   logic rd_en;
   logic bwr;
   logic trace_done;
   logic short_frm;
   logic pf_take;
   logic rd_go;
   logic out_xfer;
   logic out_done;

   assign dec_ready  = (state == WRITE);
   assign busy       = (state != WRITE);

   assign xfer       = dec_valid & dec_ready;
   assign at_end     = (cnt == ADDR_W'(MAX_LEN - 1));
   assign frame_end  = xfer & (dec_last | at_end);

   // ph = 0: read issue (cycle A), ph = 1: consume read data (cycle B)
   assign rd_en      = (state == TRACE) & ~ph;
   assign bwr        = (state == TRACE) & ph;
   assign trace_done = bwr & (t == '0);

   assign short_frm  = (len <= LW'(TAIL));
   assign nout       = len - LW'(TAIL);
   assign last_idx   = ADDR_W'(nout - 1'b1);

   assign out_xfer   = out_valid & out_ready;
   assign out_done   = out_xfer & out_last;
   assign pf_take    = pf_v & (~out_valid | out_ready);
   assign rd_go      = (state == OUTPUT) & rd_more & (~pf_v | pf_take);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WRITE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         WRITE: begin
            if (frame_end) begin
               state_nx = TRACE;
            end
         end
         TRACE: begin
            if (trace_done) begin
               state_nx = short_frm ? WRITE : OUTPUT;
            end
         end
         OUTPUT: begin
            if (out_done) begin
               state_nx = WRITE;
            end
         end
         default: state_nx = WRITE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         len     <= '0;
         t       <= '0;
         s       <= '0;
         ph      <= 1'b0;
         err_ovf <= 1'b0;
      end else begin
         if (xfer) begin
            cnt <= frame_end ? '0 : cnt + 1'b1;
            if (cnt == '0) begin
               err_ovf <= 1'b0;
            end
            if (at_end & ~dec_last) begin
               err_ovf <= 1'b1;
            end
            if (frame_end) begin
               len <= LW'(cnt) + 1'b1;
               t   <= cnt;
               s   <= '0;
               ph  <= 1'b0;
            end
         end
         if (state == TRACE) begin
            ph <= ~ph;
            if (ph) begin
               s <= {rd[s], s[5:1]};
               t <= t - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         smem[cnt] <= dec_vec;
      end
      if (rd_en) begin
         rd <= smem[t];
      end
   end

   always_ff @(posedge clk) begin
      if (bwr) begin
         bbuf[t] <= s[0];
      end
      if (rd_go) begin
         bq <= bbuf[ridx];
      end
   end

   // Prefetch stage (bq) feeds the registered output stage without bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ridx      <= '0;
         rd_more   <= 1'b0;
         pf_v      <= 1'b0;
         pf_last   <= 1'b0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (trace_done & ~short_frm) begin
            ridx    <= '0;
            rd_more <= 1'b1;
         end
         if (rd_go) begin
            ridx    <= ridx + 1'b1;
            pf_last <= (ridx == last_idx);
            rd_more <= (ridx != last_idx);
         end
         pf_v <= rd_go | (pf_v & ~pf_take);
         if (pf_take) begin
            out_valid <= 1'b1;
            out_bit   <= bq;
            out_last  <= pf_last;
         end else if (out_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Bench for viterbi_traceback: frames are built by encoding data bits into
// a trellis path with random off-path decisions; decoded bits must match the data.
module tb_viterbi_traceback;

   localparam int MAX_LEN = 4096;
   localparam int TAIL    = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dec_valid = 1'b0;
   logic [63:0] dec_vec = '0;
   logic        dec_last = 1'b0;
   logic        dec_ready;
   logic        out_valid;
   logic        out_bit;
   logic        out_last;
   logic        out_ready = 1'b1;
   logic        busy;
   logic        err_ovf;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [63:0] vq[$];
   bit          eq[$];
   bit          gq[$];
   bit          lq[$];
   int          stall_err;
   int          bubble;
   int          rdy_err;
   int          first_cyc;
   int          lx_cyc;
   bit          got_end;

   viterbi_traceback #(
      .MAX_LEN(MAX_LEN),
      .ADDR_W (12),
      .TAIL   (TAIL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .dec_valid(dec_valid),
      .dec_vec  (dec_vec),
      .dec_last (dec_last),
      .dec_ready(dec_ready),
      .out_valid(out_valid),
      .out_bit  (out_bit),
      .out_last (out_last),
      .out_ready(out_ready),
      .busy     (busy),
      .err_ovf  (err_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // mode 0: zero data, 1: bits from pat, 2: random data
   task automatic build_frame(input int nd, input bit noise,
                              input int mode, input logic [31:0] pat);
      logic [5:0]  s;
      logic [5:0]  n;
      logic [63:0] v;
      bit          b;
      s = '0;
      for (int i = 0; i < nd + TAIL; i++) begin
         b = 1'b0;
         if (i < nd) begin
            if (mode == 1) b = pat[i];
            else if (mode == 2) b = ($urandom_range(0, 1) != 0);
         end
         n = {s[4:0], b};
         v = noise ? {$urandom, $urandom} : 64'd0;
         v[n] = s[5];
         vq.push_back(v);
         if (i < nd) eq.push_back(b);
         s = n;
      end
   endtask

   task automatic drive_frame(input int st, input int n,
                              input bit lst, output bit to);
      int i;
      int g;
      bit took;
      i = 0;
      g = 0;
      while (i < n && g < 20000) begin
         dec_valid = 1'b1;
         dec_vec   = vq[st + i];
         dec_last  = lst && (i == n - 1);
         took      = dec_ready;
         @(posedge clk);
         #1;
         if (took) begin
            i++;
            lx_cyc = cyc;
         end
         g++;
      end
      dec_valid = 1'b0;
      dec_last  = 1'b0;
      dec_vec   = '0;
      to = (i < n);
   endtask

   // pat 0: always ready, 1: 1,0,0,1 repeating, other: random
   task automatic collect(input int pat, input int limit);
      int k;
      bit done;
      bit pst;
      bit pb;
      bit pl;
      bit seen;
      k = 0;
      done = 0;
      pst = 0;
      pb = 0;
      pl = 0;
      seen = 0;
      gq.delete();
      lq.delete();
      stall_err = 0;
      bubble = 0;
      rdy_err = 0;
      first_cyc = -1;
      while (!done && k < limit) begin
         if (pat == 0) out_ready = 1'b1;
         else if (pat == 1) out_ready = (k % 4 == 0) || (k % 4 == 3);
         else out_ready = ($urandom_range(0, 1) != 0);
         if (pst && (out_valid !== 1'b1 || out_bit !== pb || out_last !== pl))
            stall_err++;
         if (out_valid === 1'b1 && !seen) begin
            seen = 1;
            first_cyc = cyc;
         end
         if (seen && out_valid !== 1'b1) bubble++;
         if (seen && dec_ready !== 1'b0) rdy_err++;
         if (out_valid === 1'b1 && out_ready) begin
            gq.push_back(out_bit);
            lq.push_back(out_last);
            if (out_last) done = 1;
         end
         pst = (out_valid === 1'b1) && !out_ready;
         pb = out_bit;
         pl = out_last;
         @(posedge clk);
         #1;
         k++;
      end
      out_ready = 1'b1;
      got_end = done;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dec_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_dec_ready got=%b exp=1", dec_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_out_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (out_bit !== 1'b0) begin
         failures++;
         $display("FAIL rst_out_bit got=%b exp=0", out_bit);
      end
      checks++;
      if (out_last !== 1'b0) begin
         failures++;
         $display("FAIL rst_out_last got=%b exp=0", out_last);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_busy got=%b exp=0", busy);
      end
      checks++;
      if (err_ovf !== 1'b0) begin
         failures++;
         $display("FAIL rst_err_ovf got=%b exp=0", err_ovf);
      end
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero_path;
      bit to;
      int nl;
      vq.delete();
      eq.delete();
      build_frame(4, 1'b0, 0, 32'd0);
      fork
         drive_frame(0, vq.size(), 1'b1, to);
         collect(0, 400);
      join
      nl = 0;
      foreach (lq[i]) nl += int'(lq[i]);
      checks++;
      if (to !== 1'b0 || got_end !== 1'b1) begin
         failures++;
         $display("FAIL zero_done drive_to=%b end=%b exp 0/1", to, got_end);
      end
      checks++;
      if (gq.size() != 4) begin
         failures++;
         $display("FAIL zero_count got=%0d exp=4", gq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= gq.size() || gq[i] !== eq[i]) begin
            failures++;
            $display("FAIL zero_bit%0d got=%0d exp=%0d", i,
                     (i < gq.size()) ? int'(gq[i]) : -1, eq[i]);
         end
      end
      checks++;
      if (nl != 1) begin
         failures++;
         $display("FAIL zero_last got=%0d exp=1", nl);
      end
      checks++;
      if (bubble != 0) begin
         failures++;
         $display("FAIL zero_bubble got=%0d exp=0", bubble);
      end
      checks++;
      if (first_cyc - lx_cyc < 20) begin
         failures++;
         $display("FAIL zero_latency got=%0d exp>=20", first_cyc - lx_cyc);
      end
   endtask

   task automatic test_known_path;
      bit to;
      int nl;
      vq.delete();
      eq.delete();
      build_frame(4, 1'b0, 1, 32'hD);
      fork
         drive_frame(0, vq.size(), 1'b1, to);
         collect(0, 400);
      join
      nl = 0;
      foreach (lq[i]) nl += int'(lq[i]);
      checks++;
      if (to !== 1'b0 || got_end !== 1'b1 || gq.size() != 4) begin
         failures++;
         $display("FAIL known_done to=%b end=%b n=%0d exp 0/1/4",
                  to, got_end, gq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= gq.size() || gq[i] !== eq[i]) begin
            failures++;
            $display("FAIL known_bit%0d got=%0d exp=%0d", i,
                     (i < gq.size()) ? int'(gq[i]) : -1, eq[i]);
         end
      end
      checks++;
      if (nl != 1) begin
         failures++;
         $display("FAIL known_last got=%0d exp=1", nl);
      end
   endtask

   task automatic test_backpressure;
      bit to;
      int nl;
      vq.delete();
      eq.delete();
      build_frame(4, 1'b1, 1, 32'hD);
      fork
         drive_frame(0, vq.size(), 1'b1, to);
         collect(1, 400);
      join
      nl = 0;
      foreach (lq[i]) nl += int'(lq[i]);
      checks++;
      if (to !== 1'b0 || got_end !== 1'b1 || gq.size() != 4) begin
         failures++;
         $display("FAIL bp_done to=%b end=%b n=%0d exp 0/1/4",
                  to, got_end, gq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= gq.size() || gq[i] !== eq[i]) begin
            failures++;
            $display("FAIL bp_bit%0d got=%0d exp=%0d", i,
                     (i < gq.size()) ? int'(gq[i]) : -1, eq[i]);
         end
      end
      checks++;
      if (nl != 1) begin
         failures++;
         $display("FAIL bp_last got=%0d exp=1", nl);
      end
      checks++;
      if (stall_err != 0) begin
         failures++;
         $display("FAIL bp_stable got=%0d exp=0", stall_err);
      end
      checks++;
      if (rdy_err != 0) begin
         failures++;
         $display("FAIL bp_dec_ready got=%0d exp=0", rdy_err);
      end
   endtask

   task automatic test_short_frame;
      bit to;
      int nb;
      int ov;
      int k;
      vq.delete();
      eq.delete();
      build_frame(0, 1'b1, 0, 32'd0);
      drive_frame(0, vq.size(), 1'b1, to);
      nb = 0;
      ov = 0;
      k = 0;
      while (busy === 1'b1 && k < 100) begin
         if (out_valid !== 1'b0) ov++;
         nb++;
         @(posedge clk);
         #1;
         k++;
      end
      checks++;
      if (to !== 1'b0) begin
         failures++;
         $display("FAIL short_drive got=%b exp=0", to);
      end
      checks++;
      if (nb != 12) begin
         failures++;
         $display("FAIL short_busy got=%0d exp=12", nb);
      end
      checks++;
      if (ov != 0) begin
         failures++;
         $display("FAIL short_out_valid got=%0d exp=0", ov);
      end
      checks++;
      if (dec_ready !== 1'b1) begin
         failures++;
         $display("FAIL short_dec_ready got=%b exp=1", dec_ready);
      end
   endtask

   task automatic test_back_to_back;
      int  st[4];
      bit  tof;
      int  mis;
      int  nl;
      int  serr;
      int  rerr;
      int  ends;
      bit  acc[$];
      vq.delete();
      eq.delete();
      st[0] = 0;
      for (int f = 0; f < 3; f++) begin
         build_frame($urandom_range(1, 60), 1'b1, 2, 32'd0);
         st[f + 1] = vq.size();
      end
      tof = 0;
      nl = 0;
      serr = 0;
      rerr = 0;
      ends = 0;
      fork
         begin
            bit to;
            for (int f = 0; f < 3; f++) begin
               drive_frame(st[f], st[f + 1] - st[f], 1'b1, to);
               tof |= to;
            end
         end
         begin
            for (int f = 0; f < 3; f++) begin
               collect(2, 4000);
               foreach (gq[i]) acc.push_back(gq[i]);
               foreach (lq[i]) nl += int'(lq[i]);
               serr += stall_err;
               rerr += rdy_err;
               ends += int'(got_end);
            end
         end
      join
      mis = 0;
      foreach (eq[i]) begin
         if (i >= acc.size() || acc[i] !== eq[i]) mis++;
      end
      checks++;
      if (tof !== 1'b0 || ends != 3) begin
         failures++;
         $display("FAIL b2b_done to=%b ends=%0d exp 0/3", tof, ends);
      end
      checks++;
      if (acc.size() != eq.size()) begin
         failures++;
         $display("FAIL b2b_count got=%0d exp=%0d", acc.size(), eq.size());
      end
      checks++;
      if (mis != 0) begin
         failures++;
         $display("FAIL b2b_bits mismatches=%0d exp=0", mis);
      end
      checks++;
      if (nl != 3) begin
         failures++;
         $display("FAIL b2b_last got=%0d exp=3", nl);
      end
      checks++;
      if (serr != 0 || rerr != 0) begin
         failures++;
         $display("FAIL b2b_hold stall=%0d ready=%0d exp 0/0", serr, rerr);
      end
   endtask

   task automatic test_overflow;
      bit to;
      int ones;
      int nl;
      int ov;
      vq.delete();
      eq.delete();
      for (int i = 0; i < MAX_LEN + 3; i++) vq.push_back(64'd0);
      drive_frame(0, MAX_LEN - 1, 1'b0, to);
      checks++;
      if (to !== 1'b0 || err_ovf !== 1'b0 || dec_ready !== 1'b1) begin
         failures++;
         $display("FAIL ovf_pre to=%b err=%b rdy=%b exp 0/0/1",
                  to, err_ovf, dec_ready);
      end
      drive_frame(MAX_LEN - 1, 1, 1'b0, to);
      checks++;
      if (err_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set got=%b exp=1", err_ovf);
      end
      checks++;
      if (dec_ready !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL ovf_hold rdy=%b busy=%b exp 0/1", dec_ready, busy);
      end
      collect(0, 20000);
      ones = 0;
      nl = 0;
      foreach (gq[i]) ones += int'(gq[i]);
      foreach (lq[i]) nl += int'(lq[i]);
      checks++;
      if (got_end !== 1'b1 || gq.size() != MAX_LEN - TAIL) begin
         failures++;
         $display("FAIL ovf_count end=%b got=%0d exp=%0d",
                  got_end, gq.size(), MAX_LEN - TAIL);
      end
      checks++;
      if (ones != 0 || nl != 1) begin
         failures++;
         $display("FAIL ovf_bits ones=%0d lasts=%0d exp 0/1", ones, nl);
      end
      checks++;
      if (bubble != 0) begin
         failures++;
         $display("FAIL ovf_bubble got=%0d exp=0", bubble);
      end
      checks++;
      if (err_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_sticky got=%b exp=1", err_ovf);
      end
      drive_frame(MAX_LEN, 1, 1'b0, to);
      checks++;
      if (err_ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear got=%b exp=0", err_ovf);
      end
      drive_frame(MAX_LEN + 1, 2, 1'b1, to);
      ov = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid !== 1'b0) ov++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (to !== 1'b0 || ov != 0 || dec_ready !== 1'b1) begin
         failures++;
         $display("FAIL ovf_tail to=%b valid=%0d rdy=%b exp 0/0/1",
                  to, ov, dec_ready);
      end
   endtask

   task automatic test_reset_mid;
      bit to;
      int k;
      vq.delete();
      eq.delete();
      build_frame(4, 1'b1, 1, 32'hD);
      drive_frame(0, vq.size(), 1'b1, to);
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rmid_trace_busy got=%b exp=1", busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || dec_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rmid_trace busy=%b rdy=%b valid=%b exp 0/1/0",
                  busy, dec_ready, out_valid);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      vq.delete();
      eq.delete();
      build_frame(20, 1'b1, 1, 32'hA5A5F00F);
      out_ready = 1'b0;
      drive_frame(0, vq.size(), 1'b1, to);
      k = 0;
      while (out_valid !== 1'b1 && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      checks++;
      if (out_valid !== 1'b1 || out_bit !== eq[0]) begin
         failures++;
         $display("FAIL rmid_first valid=%b bit=%b exp 1/%b",
                  out_valid, out_bit, eq[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_bit !== 1'b0 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL rmid_out valid=%b bit=%b last=%b exp 0/0/0",
                  out_valid, out_bit, out_last);
      end
      checks++;
      if (busy !== 1'b0 || dec_ready !== 1'b1) begin
         failures++;
         $display("FAIL rmid_state busy=%b rdy=%b exp 0/1", busy, dec_ready);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      vq.delete();
      eq.delete();
      build_frame(4, 1'b1, 1, 32'hD);
      fork
         drive_frame(0, vq.size(), 1'b1, to);
         collect(0, 400);
      join
      checks++;
      if (got_end !== 1'b1 || gq.size() != 4) begin
         failures++;
         $display("FAIL rmid_count end=%b got=%0d exp 1/4", got_end, gq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= gq.size() || gq[i] !== eq[i]) begin
            failures++;
            $display("FAIL rmid_bit%0d got=%0d exp=%0d", i,
                     (i < gq.size()) ? int'(gq[i]) : -1, eq[i]);
         end
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_zero_path();
      test_known_path();
      test_backpressure();
      test_short_frame();
      test_back_to_back();
      test_overflow();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
